uart_fifo_core: RTL
===================

Name: uart_fifo_core

Overview:
- Next-generation UART for the design. Adds per-direction FIFO buffering, optional parity, 16x-oversampled receive and error reporting.
- Sits between board-level i_rx/o_tx pins and the processing logic.
- Host side is a simple write/read FIFO interface, so bursts of bytes are accepted without per-byte handshaking with the serialiser.

Parameters:
- clk_speed, 100_000000, system clock frequency in Hz
- baudrate, 921600, line rate in baud
- D_BITS, 8, data bits per frame (5..9)
- SP_BITS, 1, stop bits (1 or 2)
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
- FIFO_DEPTH, 16, entries per FIFO (power of two, >= 2)

Ports:
- i_clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- i_rx  input  1  serial receive line (asynchronous)
- o_tx  output  1  serial transmit line
- tx_data  input  D_BITS  byte to transmit
- tx_wr  input  1  push tx_data into TX FIFO
- tx_full  output  1  TX FIFO full
- tx_busy  output  1  TX FIFO non-empty or frame in progress
- rx_data  output  D_BITS  head of RX FIFO (first-word fall-through)
- rx_rd  input  1  pop RX FIFO head
- rx_empty  output  1  RX FIFO empty
- rx_count  output  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
- rx_frame_err  output  1  1-cycle pulse: stop bit sampled low
- rx_parity_err  output  1  1-cycle pulse: parity mismatch
- rx_overrun  output  1  1-cycle pulse: byte dropped, RX FIFO full

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Reset values:
  - o_tx = 1, tx_full = 0, tx_busy = 0
  - rx_empty = 1, rx_count = 0, rx_data = 0
  - all error pulses = 0
  - FIFOs emptied, both FSMs in IDLE
- Reset mid-frame: o_tx returns to 1 on the cycle after reset is sampled; any partial frame is discarded.
- Tick generator:
  - DIV = round(clk_speed / (baudrate*16)); the default gives 7.
  - A free-running counter produces a 1-cycle tick every DIV clocks.
  - One bit time = 16 ticks.
- Frame format: start(0), D_BITS data LSB-first, optional parity bit, SP_BITS stop bits(1).
- TX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
  - IDLE pops the FIFO head when non-empty and moves to START; o_tx drops on the next tick boundary.
  - PARITY is skipped when PARITY = 0.
  - At STOP end: if the FIFO is non-empty, go directly to START with no idle gap; otherwise go to IDLE.
- TX FIFO:
  - tx_wr while tx_full is ignored; no stored data changes.
  - tx_wr while not full is accepted that cycle.
  - Simultaneous tx_wr and internal pop are both performed.
- RX input: i_rx passes through a 2-flop synchroniser, giving 2 cycles of latency.
- RX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
  - IDLE: waits for the synchronised line low.
  - START: re-samples at tick 8 (mid-bit). If high, treat as a glitch and return to IDLE with no error.
  - DATA/PARITY: each bit is sampled at tick 16 after the previous sample, i.e. mid-bit.
  - STOP: only the first stop bit is checked.
- RX frame completion, evaluated on the stop sample:
  - stop = 0: rx_frame_err pulses; byte discarded.
  - else parity mismatch: rx_parity_err pulses; byte discarded.
  - else RX FIFO full: rx_overrun pulses; byte discarded; existing contents unchanged.
  - else byte written; rx_empty deasserts the following cycle.
- FSM return: the FSM returns to IDLE immediately after the stop sample, so back-to-back frames are received.
- Error priority: frame > parity > overrun. Only one error pulse fires per frame.
- RX FIFO:
  - rx_rd while rx_empty is ignored.
  - Read and write on the same cycle when full: both performed, count unchanged.
  - rx_data updates the cycle after a pop or after a write into an empty FIFO.
- FIFO pointers: $clog2(FIFO_DEPTH)+1 bits; wrap-around uses the MSB to distinguish full from empty.

Test Plan:
- Loopback, defaults: o_tx tied to i_rx; write 0x55, 0xA3, 0x00, 0xFF back-to-back → RX FIFO holds the same 4 bytes in order, rx_count = 4, no error pulses, tx_busy falls after 4 frames (≈4×10×112 clocks).
- TX bit timing: write 0xA5 → o_tx low for 112 clocks, then bits 1,0,1,0,0,1,0,1 at 112 clocks each, then high. The next byte's start bit follows the stop bit directly when queued.
- Parity, PARITY = 2: receive 0x07 with parity bit 1 → accepted. Same frame with parity bit 0 → rx_parity_err pulses once, rx_count unchanged.
- Errors and glitch: drive the stop bit low → rx_frame_err pulses, no write. Drive a 3-clock low glitch on an idle line → FSM returns to IDLE, no error, no write.
- Full/overrun, FIFO_DEPTH = 16: send 17 bytes without rx_rd → rx_count = 16 and rx_overrun pulses on byte 17. Then assert rx_rd and receive a byte in the same cycle → count stays 16. Writes to TX with tx_full = 1 are ignored.
- Reset mid-frame: assert reset during DATA of a TX and an RX frame → next cycle o_tx = 1, rx_empty = 1, tx_busy = 0. A subsequent clean frame is received correctly.

Source files
------------

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with per-direction FIFOs, optional parity,
// 16x-oversampled receiver and one-cycle error pulses.

// Synchronous FIFO. The parent qualifies wr/rd; this block only moves pointers.
// Pointers carry one extra MSB so full and empty are told apart on wrap.
module uart_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  // pointer update; read and write on the same cycle are both honoured
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // first-word fall-through head, forced to zero while empty
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

module uart_fifo_core #(
  parameter int clk_speed  = 100_000000,
  parameter int baudrate   = 921600,
  parameter int D_BITS     = 8,
  parameter int SP_BITS    = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          reset,
  input  logic                          i_rx,
  output logic                          o_tx,
  input  logic [D_BITS-1:0]             tx_data,
  input  logic                          tx_wr,
  output logic                          tx_full,
  output logic                          tx_busy,
  output logic [D_BITS-1:0]             rx_data,
  input  logic                          rx_rd,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_overrun
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  // rounded divide: clocks per oversample tick
  localparam int DIV_R = (clk_speed + baudrate * 8) / (baudrate * 16);
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // parity bit that makes the frame odd (1) or even (2)
  function automatic logic par_of(input logic [D_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------- tick
  logic [DW-1:0] div_cnt;
  logic          tick;

  // free-running divider, one tick every DIV clocks
  always_ff @(posedge i_clk) begin
    if (reset)                           div_cnt <= '0;
    else if (div_cnt == DW'(DIV - 1))    div_cnt <= '0;
    else                                 div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  // ---------------------------------------------------------------- TX
  logic              tx_push, tx_pop, tx_empty;
  logic [D_BITS-1:0] tx_head;
  logic [CW-1:0]     tx_count;

  logic [2:0]        tx_st;
  logic [3:0]        tx_sc;      // tick within current bit
  logic [3:0]        tx_bit;     // data / stop bit index
  logic [D_BITS-1:0] tx_sh;
  logic              tx_par;
  logic              tx_arm;     // waiting for the tick that opens the start bit
  logic              tx_line;
  logic              tx_last_stop;

  assign tx_push      = tx_wr && !tx_full;
  assign tx_last_stop = (tx_st == S_STOP) && tick && (tx_sc == 4'hF) &&
                        (tx_bit == 4'(SP_BITS - 1));
  assign tx_pop       = !tx_empty && ((tx_st == S_IDLE) || tx_last_stop);

  uart_fifo #(.W(D_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (i_clk),
    .reset (reset),
    .wr    (tx_push),
    .wdata (tx_data),
    .rd    (tx_pop),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  // TX serialiser: every line change lands on a tick, 16 ticks per bit
  always_ff @(posedge i_clk) begin
    if (reset) begin
      tx_st   <= S_IDLE;
      tx_sc   <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      tx_par  <= 1'b0;
      tx_arm  <= 1'b0;
      tx_line <= 1'b1;
    end else begin
      case (tx_st)
        S_IDLE: begin
          if (!tx_empty) begin
            tx_st  <= S_START;
            tx_sh  <= tx_head;
            tx_par <= par_of(tx_head);
            tx_arm <= 1'b1;
            tx_sc  <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (tx_arm) begin
              tx_arm  <= 1'b0;
              tx_line <= 1'b0;
              tx_sc   <= '0;
            end else if (tx_sc == 4'hF) begin
              tx_st   <= S_DATA;
              tx_bit  <= '0;
              tx_sc   <= '0;
              tx_line <= tx_sh[0];
            end else begin
              tx_sc <= tx_sc + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            tx_sc <= tx_sc + 4'd1;
            if (tx_sc == 4'hF) begin
              if (tx_bit == 4'(D_BITS - 1)) begin
                tx_bit <= '0;
                if (PARITY != 0) begin
                  tx_st   <= S_PAR;
                  tx_line <= tx_par;
                end else begin
                  tx_st   <= S_STOP;
                  tx_line <= 1'b1;
                end
              end else begin
                tx_bit  <= tx_bit + 4'd1;
                tx_sh   <= tx_sh >> 1;
                tx_line <= tx_sh[1];
              end
            end
          end
        end
        S_PAR: begin
          if (tick) begin
            tx_sc <= tx_sc + 4'd1;
            if (tx_sc == 4'hF) begin
              tx_st   <= S_STOP;
              tx_bit  <= '0;
              tx_line <= 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            tx_sc <= tx_sc + 4'd1;
            if (tx_sc == 4'hF) begin
              if (tx_bit == 4'(SP_BITS - 1)) begin
                tx_bit <= '0;
                if (!tx_empty) begin
                  // queued byte: start bit follows stop with no idle gap
                  tx_st   <= S_START;
                  tx_sh   <= tx_head;
                  tx_par  <= par_of(tx_head);
                  tx_arm  <= 1'b0;
                  tx_line <= 1'b0;
                end else begin
                  tx_st <= S_IDLE;
                end
              end else begin
                tx_bit <= tx_bit + 4'd1;
              end
            end
          end
        end
        default: begin
          tx_st   <= S_IDLE;
          tx_line <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx    = tx_line;
  assign tx_busy = (tx_count != '0) || (tx_st != S_IDLE);

  // ---------------------------------------------------------------- RX
  logic [1:0]        rx_pipe;
  logic              rx_s;
  logic [2:0]        rx_st;
  logic [3:0]        rx_sc;
  logic [3:0]        rx_bit;
  logic [D_BITS-1:0] rx_sh;
  logic              rx_pbit;

  logic rx_stop_smp, rx_bad_par, rx_wr_req, rx_do_rd, rx_push, rx_full;

  // two-flop synchroniser for the asynchronous line; idles high
  always_ff @(posedge i_clk) begin
    if (reset) rx_pipe <= 2'b11;
    else       rx_pipe <= {rx_pipe[0], i_rx};
  end

  assign rx_s = rx_pipe[1];

  // RX sampler: confirm start at mid-bit, then sample every 16 ticks
  always_ff @(posedge i_clk) begin
    if (reset) begin
      rx_st   <= S_IDLE;
      rx_sc   <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_pbit <= 1'b0;
    end else begin
      case (rx_st)
        S_IDLE: begin
          if (!rx_s) begin
            rx_st <= S_START;
            rx_sc <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_sc == 4'd7) begin
              rx_sc  <= '0;
              rx_bit <= '0;
              // line back high by mid-bit: a glitch, not a start bit
              rx_st  <= rx_s ? S_IDLE : S_DATA;
            end else begin
              rx_sc <= rx_sc + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            rx_sc <= rx_sc + 4'd1;
            if (rx_sc == 4'hF) begin
              rx_sh <= {rx_s, rx_sh[D_BITS-1:1]};
              if (rx_bit == 4'(D_BITS - 1)) rx_st <= (PARITY != 0) ? S_PAR : S_STOP;
              else                          rx_bit <= rx_bit + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (tick) begin
            rx_sc <= rx_sc + 4'd1;
            if (rx_sc == 4'hF) begin
              rx_pbit <= rx_s;
              rx_st   <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            rx_sc <= rx_sc + 4'd1;
            // only the first stop bit is checked, then straight back to idle
            if (rx_sc == 4'hF) rx_st <= S_IDLE;
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  assign rx_stop_smp = (rx_st == S_STOP) && tick && (rx_sc == 4'hF);
  assign rx_bad_par  = (PARITY != 0) && (rx_pbit != par_of(rx_sh));
  assign rx_wr_req   = rx_stop_smp && rx_s && !rx_bad_par;
  assign rx_do_rd    = rx_rd && !rx_empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign rx_push     = rx_wr_req && (!rx_full || rx_do_rd);

  uart_fifo #(.W(D_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (i_clk),
    .reset (reset),
    .wr    (rx_push),
    .wdata (rx_sh),
    .rd    (rx_do_rd),
    .rdata (rx_data),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  // error pulses, mutually exclusive: frame > parity > overrun
  always_ff @(posedge i_clk) begin
    if (reset) begin
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_frame_err  <= rx_stop_smp && !rx_s;
      rx_parity_err <= rx_stop_smp && rx_s && rx_bad_par;
      rx_overrun    <= rx_wr_req && rx_full && !rx_do_rd;
    end
  end
endmodule
